alu_cc_pipe: RTL

- Parametrised, pipelined successor to the combinational 64-bit ADD unit in the Y86-64 execute stage.
- Performs ADD, SUB, AND and XOR on WIDTH-bit signed operands through two register stages, with valid/ready handshakes on both sides.
- Produces ZF/SF/OF and carry per result, and holds the architectural condition-code register.
- Evaluates Y86 branch/cmov conditions from that register.

---
 rtl/alu_cc_pipe_if.sv | 32 +++
 rtl/alu_cc_pipe.sv | 88 ++++++++
 2 files changed

// File: rtl/alu_cc_pipe_if.sv
// alu_cc_pipe_if: operation/result handshakes, condition-code view and condition query of the ALU pipe
interface alu_cc_pipe_if #(parameter int WIDTH = 64);
  logic in_valid;
  logic in_ready;
  logic [3:0] in_ifun;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic in_set_cc;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_result;
  logic out_cout;
  logic out_zf;
  logic out_sf;
  logic out_of;
  logic out_err;
  logic cc_zf;
  logic cc_sf;
  logic cc_of;
  logic [2:0] cond_fn;
  logic cond_true;
  modport master (
    output in_valid, in_ifun, in_a, in_b, in_set_cc, out_ready, cond_fn,
    input in_ready, out_valid, out_result, out_cout, out_zf, out_sf, out_of, out_err,
    input cc_zf, cc_sf, cc_of, cond_true
  );
  modport slave (
    input in_valid, in_ifun, in_a, in_b, in_set_cc, out_ready, cond_fn,
    output in_ready, out_valid, out_result, out_cout, out_zf, out_sf, out_of, out_err,
    output cc_zf, cc_sf, cc_of, cond_true
  );
endinterface

// File: rtl/alu_cc_pipe.sv
// alu_cc_pipe: two-stage ADD/SUB/AND/XOR unit with flags, CC register and Y86 condition evaluation
module alu_cc_pipe #(
  parameter int WIDTH = 64
) (
  input logic clk,
  input logic rst,
  alu_cc_pipe_if.slave bus
);
  localparam int M = WIDTH - 1;
  logic s1_valid_q, s1_set_cc_q;
  logic [3:0] s1_ifun_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic out_valid_q, s2_set_cc_q, cout_q, zf_q, sf_q, of_q, err_q;
  logic [WIDTH-1:0] res_q;
  logic cc_zf_q, cc_sf_q, cc_of_q;
  logic s1_load, s2_load, retire, legal, is_sub, cout_d, of_d, lt;
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] res_d;
  logic [7:0] conds;
  assign bus.in_ready = !s1_valid_q | !out_valid_q | bus.out_ready;
  assign s1_load = bus.in_valid & bus.in_ready;
  assign s2_load = s1_valid_q & (!out_valid_q | bus.out_ready);
  assign retire = out_valid_q & bus.out_ready;
  always_comb begin
    legal = s1_ifun_q < 4'd4;
    is_sub = s1_ifun_q == 4'd1;
    sum = {1'b0, s1_b_q} + {1'b0, is_sub ? ~s1_a_q : s1_a_q} + {{WIDTH{1'b0}}, is_sub};
    res_d = !legal ? '0 :
            s1_ifun_q == 4'd2 ? s1_a_q & s1_b_q :
            s1_ifun_q == 4'd3 ? s1_a_q ^ s1_b_q : sum[M:0];
    cout_d = legal & !s1_ifun_q[1] & sum[WIDTH];
    of_d = s1_ifun_q == 4'd0 ? (s1_a_q[M] == s1_b_q[M]) & (res_d[M] != s1_a_q[M]) :
           is_sub ? (s1_a_q[M] != s1_b_q[M]) & (res_d[M] != s1_b_q[M]) : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      res_q <= '0;
      cout_q <= 1'b0;
      zf_q <= 1'b0;
      sf_q <= 1'b0;
      of_q <= 1'b0;
      err_q <= 1'b0;
      s2_set_cc_q <= 1'b0;
      cc_zf_q <= 1'b1;
      cc_sf_q <= 1'b0;
      cc_of_q <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_ifun_q <= bus.in_ifun;
        s1_a_q <= bus.in_a;
        s1_b_q <= bus.in_b;
        s1_set_cc_q <= bus.in_set_cc;
      end
      s1_valid_q <= s1_load | (s1_valid_q & !s2_load);
      // an illegal op yields a zero result but must not report ZF
      if (s2_load) begin
        res_q <= res_d;
        cout_q <= cout_d;
        zf_q <= legal & (res_d == '0);
        sf_q <= res_d[M];
        of_q <= of_d;
        err_q <= !legal;
        s2_set_cc_q <= s1_set_cc_q;
      end
      out_valid_q <= s2_load | (out_valid_q & !retire);
      if (retire & !err_q & s2_set_cc_q) begin
        cc_zf_q <= zf_q;
        cc_sf_q <= sf_q;
        cc_of_q <= of_q;
      end
    end
  end
  assign lt = cc_sf_q ^ cc_of_q;
  assign conds = {1'b0, !lt & !cc_zf_q, !lt, !cc_zf_q, cc_zf_q, lt, lt | cc_zf_q, 1'b1};
  assign bus.cond_true = conds[bus.cond_fn];
  assign bus.out_valid = out_valid_q;
  assign bus.out_result = res_q;
  assign bus.out_cout = cout_q;
  assign bus.out_zf = zf_q;
  assign bus.out_sf = sf_q;
  assign bus.out_of = of_q;
  assign bus.out_err = err_q;
  assign bus.cc_zf = cc_zf_q;
  assign bus.cc_sf = cc_sf_q;
  assign bus.cc_of = cc_of_q;
endmodule
